irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 11 +
 rtl/prio_enc.sv | 17 +
 rtl/irq_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: register map, FSM state encoding and vector helper shared by irq_ctrl
package irq_pkg;
  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_MODE = 2'd1;
  localparam logic [1:0] A_PEND = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERV} state_t;
  function automatic logic [7:0] vec_of(input logic [7:0] base, input logic [2:0] idx);
    return base + {4'b0, idx, 1'b0};
  endfunction
endpackage

// File: rtl/prio_enc.sv
// prio_enc: lowest-index-wins priority encoder
//   i_req : request vector
//   o_idx : index of the lowest set request (0 when none)
//   o_any : at least one request set
module prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic [2:0]   o_idx,
  output logic         o_any
);
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) if (i_req[i]) o_idx = 3'(i);
  end
  assign o_any = |i_req;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller with edge/level sources and vectored acknowledge
//   ph0, reset          : clock, async active-high reset
//   src                 : raw interrupt lines (synchronised internally)
//   reg_addr/wdata/we   : register write port (MASK, MODE, PENDING W1C, CTRL/EOI)
//   reg_rdata           : combinational register read
//   irq_out, ack        : request to the core and its acknowledge
//   vector/vector_valid : vector delivered the cycle after an accepted ack
module irq_ctrl import irq_pkg::*; #(
  parameter int         NUM_SRC  = 8,
  parameter logic [7:0] VBASE    = 8'hE0,
  parameter logic [7:0] SPUR_VEC = 8'hFE
) (
  input  logic               ph0,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [1:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  input  logic               reg_we,
  output logic [7:0]         reg_rdata,
  output logic               irq_out,
  input  logic               ack,
  output logic [7:0]         vector,
  output logic               vector_valid
);
  logic [NUM_SRC-1:0] r_s1, r_s2, r_s3, r_mask, r_mode, r_pend;
  logic [NUM_SRC-1:0] w_edge, w_pend, w_req, w_clr, w_ack_clr;
  logic [1:0]         r_warm;
  logic               r_insvc, r_irq, r_vvalid;
  logic [2:0]         r_idx, w_idx;
  logic [7:0]         r_vec, w_mask8, w_mode8, w_pend8;
  logic               w_any, w_acc, w_eoi;
  state_t             r_state, w_state_nxt;
  // Edges are only trusted once the history flop holds a real sample, so a
  // line already high at reset release is not mistaken for a rising edge.
  assign w_edge = (r_warm == 2'd3) ? (r_s2 & ~r_s3) : '0;
  assign w_pend = (r_pend & r_mode) | (r_s2 & ~r_mode);
  assign w_req  = w_pend & r_mask;
  prio_enc #(.N(NUM_SRC)) u_prio (.i_req(w_req), .o_idx(w_idx), .o_any(w_any));
  assign w_acc = ack && (r_state == ST_REQ);
  assign w_eoi = reg_we && (reg_addr == A_CTRL) && (r_state == ST_SERV);
  assign w_clr = (reg_we && reg_addr == A_PEND) ? reg_wdata[NUM_SRC-1:0] : '0;
  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) w_ack_clr[i] = w_acc && w_any && (w_idx == 3'(i));
  end
  always_comb begin
    w_state_nxt = r_state == ST_IDLE ? (w_any ? ST_REQ : ST_IDLE) :
                  r_state == ST_REQ  ? (ack ? (w_any ? ST_SERV : ST_IDLE) : ST_REQ) :
                  (r_state == ST_SERV && !w_eoi) ? ST_SERV : ST_IDLE;
  end
  always_ff @(posedge ph0 or posedge reset)
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge ph0 or posedge reset)
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_warm <= '0;
      r_mask <= '0;
      r_mode <= '1;
      r_pend <= '0;
    end else begin
      r_s1 <= src;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
      if (reg_we && reg_addr == A_MASK) r_mask <= reg_wdata[NUM_SRC-1:0];
      if (reg_we && reg_addr == A_MODE) r_mode <= reg_wdata[NUM_SRC-1:0];
      // a new edge overrides a same-cycle W1C or ack clear
      r_pend <= ((r_pend & ~w_clr & ~w_ack_clr) | w_edge) & r_mode;
    end
  always_ff @(posedge ph0 or posedge reset)
    if (reset) begin
      r_irq    <= 1'b0;
      r_vvalid <= 1'b0;
      r_vec    <= 8'h00;
      r_insvc  <= 1'b0;
      r_idx    <= 3'd0;
    end else begin
      r_irq    <= w_state_nxt == ST_REQ;
      r_vvalid <= w_acc;
      if (w_acc) r_vec <= w_any ? vec_of(VBASE, w_idx) : SPUR_VEC;
      if (w_acc && w_any) begin
        r_insvc <= 1'b1;
        r_idx   <= w_idx;
      end else if (w_eoi) begin
        r_insvc <= 1'b0;
        r_idx   <= 3'd0;
      end
    end
  always_comb begin
    w_mask8 = '0;
    w_mode8 = '0;
    w_pend8 = '0;
    w_mask8[NUM_SRC-1:0] = r_mask;
    w_mode8[NUM_SRC-1:0] = r_mode;
    w_pend8[NUM_SRC-1:0] = w_pend;
    reg_rdata = reg_addr == A_MASK ? w_mask8 :
                reg_addr == A_MODE ? w_mode8 :
                reg_addr == A_PEND ? w_pend8 : {r_insvc, 4'b0, r_idx};
  end
  assign irq_out      = r_irq;
  assign vector       = r_vec;
  assign vector_valid = r_vvalid;
endmodule
